// File: rtl/systolic_drain_requant_if.sv
// Drain-side bus: per-row accumulator streams in, requantized byte stream out.
// slave is the drain block, master is whoever feeds it and consumes its output.
interface systolic_drain_requant_if #(
  parameter int N       = 4,
  parameter int D_W_ACC = 32,
  parameter int D_W_OUT = 8,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5
);
  logic [N*D_W_ACC-1:0] in_data;
  logic [N-1:0]         in_valid;
  logic [MULT_W-1:0]    scale;
  logic [SHIFT_W-1:0]   shift;
  logic [D_W_OUT-1:0]   m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;
  logic                 busy;
  logic                 overflow;

  modport master (
    output in_data, in_valid, scale, shift, m_ready,
    input  m_data, m_valid, m_last, busy, overflow
  );
  modport slave (
    input  in_data, in_valid, scale, shift, m_ready,
    output m_data, m_valid, m_last, busy, overflow
  );
endinterface

// File: rtl/systolic_drain_requant.sv
// Per-row FWFT FIFOs behind the PE array, drained row-major through a two-stage
// requant pipeline (multiply, then round/shift/saturate) onto a stallable stream.
module systolic_drain_requant #(
  parameter int N          = 4,
  parameter int D_W_ACC    = 32,
  parameter int D_W_OUT    = 8,
  parameter int MULT_W     = 16,
  parameter int SHIFT_W    = 5,
  parameter int FIFO_DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  systolic_drain_requant_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = D_W_ACC + MULT_W;
  localparam logic signed [PW:0] OMAX = {{(PW+2-D_W_OUT){1'b0}}, {(D_W_OUT-1){1'b1}}};
  localparam logic signed [PW:0] OMIN = ~OMAX;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_e;

  state_e                   state_q;
  logic [RW-1:0]            row_q, col_q;
  logic signed [MULT_W-1:0] scale_q, scale_eff;
  logic [SHIFT_W-1:0]       shift_q;

  logic [N-1:0]              empty, rd, ovf_hit;
  logic [N-1:0][D_W_ACC-1:0] head;
  logic                      en, issue, issue_last;

  logic                     p_vld_q, p_last_q;
  logic signed [PW-1:0]     p_q, p_d, a_ext, s_ext;
  logic signed [PW:0]       rnd, half;
  logic [D_W_OUT-1:0]       q_d;
  logic                     m_valid_q, m_last_q, overflow_q;
  logic [D_W_OUT-1:0]       m_data_q;

  assign en = !m_valid_q || bus.m_ready;
  // IDLE issues the first read in the same cycle it samples the config, so the
  // first product uses the live scale input; this keeps read-to-output at 2 cycles.
  assign issue      = en && (state_q != FLUSH) && !empty[row_q];
  assign issue_last = issue && (row_q == RW'(N-1)) && (col_q == RW'(N-1));

  for (genvar r = 0; r < N; r++) begin : g_row
    logic [D_W_ACC-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]        wptr_q, rptr_q;
    logic               full, wr;

    assign empty[r]   = (wptr_q == rptr_q);
    assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd[r]      = issue && (row_q == RW'(r));
    assign wr         = bus.in_valid[r] && (!full || rd[r]);
    assign ovf_hit[r] = bus.in_valid[r] && full && !rd[r];
    assign head[r]    = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
      if (rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr)    wptr_q <= wptr_q + (AW+1)'(1);
        if (rd[r]) rptr_q <= rptr_q + (AW+1)'(1);
      end
    end

    always_ff @(posedge clk)
      if (wr) mem_q[wptr_q[AW-1:0]] <= bus.in_data[r*D_W_ACC +: D_W_ACC];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      scale_q <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (!empty[0]) begin
          scale_q <= $signed(bus.scale);
          shift_q <= bus.shift;
          state_q <= DRAIN;
        end
        FLUSH: if (!p_vld_q && !m_valid_q) state_q <= IDLE;
        default: ;
      endcase
      if (issue) begin
        if (issue_last) begin
          row_q   <= '0;
          col_q   <= '0;
          state_q <= FLUSH;
        end else if (col_q == RW'(N-1)) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + RW'(1);
        end
      end
    end
  end

  assign scale_eff = (state_q == IDLE) ? $signed(bus.scale) : scale_q;
  assign a_ext     = {{MULT_W{head[row_q][D_W_ACC-1]}}, head[row_q]};
  assign s_ext     = {{D_W_ACC{scale_eff[MULT_W-1]}}, scale_eff};
  assign p_d       = a_ext * s_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_vld_q  <= 1'b0;
      p_last_q <= 1'b0;
      p_q      <= '0;
    end else if (en) begin
      p_vld_q  <= issue;
      p_last_q <= issue_last;
      if (issue) p_q <= p_d;
    end
  end

  // One extra headroom bit so the rounding add can never wrap.
  always_comb begin
    half = '0;
    rnd  = {p_q[PW-1], p_q};
    if (shift_q != '0) begin
      half[shift_q - SHIFT_W'(1)] = 1'b1;
      rnd = (rnd + half) >>> shift_q;
    end
    if (rnd > OMAX)      q_d = OMAX[D_W_OUT-1:0];
    else if (rnd < OMIN) q_d = OMIN[D_W_OUT-1:0];
    else                 q_d = rnd[D_W_OUT-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else if (en) begin
      m_valid_q <= p_vld_q;
      m_last_q  <= p_last_q;
      if (p_vld_q) m_data_q <= q_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           overflow_q <= 1'b0;
    else if (|ovf_hit) overflow_q <= 1'b1;
  end

  assign bus.m_data   = m_data_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_last   = m_last_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q != IDLE) || p_vld_q || m_valid_q;
endmodule

// File: tb/tb_systolic_drain_requant.sv
// Bench for systolic_drain_requant: per-row queue model of the drain order plus
// integer requant arithmetic, directed vectors and randomized tiles.
module tb_systolic_drain_requant;
  localparam int N = 4, D_W_ACC = 32, D_W_OUT = 8, MULT_W = 16, SHIFT_W = 5, FIFO_DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_drain_requant_if #(.N(N), .D_W_ACC(D_W_ACC), .D_W_OUT(D_W_OUT),
                              .MULT_W(MULT_W), .SHIFT_W(SHIFT_W)) bus ();

  systolic_drain_requant #(.N(N), .D_W_ACC(D_W_ACC), .D_W_OUT(D_W_OUT), .MULT_W(MULT_W),
                           .SHIFT_W(SHIFT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  typedef struct {int data; bit last;} out_t;
  typedef struct {int acc; int scale; int shift; int exp;} vec_t;

  int   n_cmp = 0, n_bad = 0, cyc = 0, first_mv = -1;
  int   rdy_mode = 0, cur_row = 0, cfg_scale = 1, cfg_shift = 0;
  out_t got_q[$], exp_q[$], last_got[$];
  int   mq[N][$];
  int   tile_v[N][N];
  vec_t vt[14];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: full-precision product, floor((p + 2^(sh-1)) / 2^sh), clamp to int8.
  function automatic int requant(int acc, int sc, int sh);
    longint p, r;
    p = longint'(acc) * longint'(sc);
    if (sh > 0) r = (p + (longint'(1) << (sh - 1))) >>> sh;
    else        r = p;
    if (r > 127)  return 127;
    if (r < -128) return -128;
    return int'(r);
  endfunction

  // Output order is row-major per tile; a row's results are known once N values arrived.
  function automatic void model_push(int r, int acc);
    out_t o;
    mq[r].push_back(acc);
    while (mq[cur_row].size() >= N) begin
      for (int c = 0; c < N; c++) begin
        o.data = requant(mq[cur_row].pop_front(), cfg_scale, cfg_shift);
        o.last = (cur_row == N-1) && (c == N-1);
        exp_q.push_back(o);
      end
      cur_row = (cur_row + 1) % N;
    end
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < N; r++) mq[r].delete();
    cur_row = 0;
    exp_q.delete();
    got_q.delete();
  endfunction

  task automatic set_cfg(input int sc, input int sh);
    bus.scale = MULT_W'(sc);
    bus.shift = SHIFT_W'(sh);
    cfg_scale = sc;
    cfg_shift = sh;
  endtask

  task automatic put(input logic [N-1:0] v, input logic [N*D_W_ACC-1:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk); #1;
    for (int r = 0; r < N; r++)
      if (v[r]) model_push(r, $signed(d[r*D_W_ACC +: D_W_ACC]));
    bus.in_valid = '0;
  endtask

  task automatic send_tile(input int skew);
    logic [N-1:0] v;
    logic [N*D_W_ACC-1:0] d;
    int c;
    for (int k = 0; k < N + skew*(N-1); k++) begin
      v = '0;
      d = '0;
      for (int r = 0; r < N; r++) begin
        c = k - r*skew;
        if (c >= 0 && c < N) begin
          v[r] = 1'b1;
          d[r*D_W_ACC +: D_W_ACC] = tile_v[r][c];
        end
      end
      put(v, d);
    end
  endtask

  task automatic wait_got(input string name, input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 3000) begin @(negedge clk); t++; end
    if (got_q.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: got %0d outputs, expected %0d", name, got_q.size(), n);
    end
  endtask

  task automatic drain_check(input string name, input int n);
    out_t g, e;
    wait_got(name, n);
    last_got.delete();
    for (int i = 0; i < n && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      last_got.push_back(g);
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL %s extra output: got %0d, expected none", name, g.data);
      end else begin
        e = exp_q.pop_front();
        check({name, "_data"}, g.data, e.data);
        check({name, "_last"}, g.last, e.last);
      end
    end
  endtask

  task automatic rdy_drv();
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = 1'b0;
      endcase
    end
  endtask

  task automatic monitor();
    logic pstall, plast;
    logic [D_W_OUT-1:0] pdata;
    out_t o;
    pstall = 1'b0; plast = 1'b0; pdata = '0;
    forever begin
      @(negedge clk);
      if (rst) pstall = 1'b0;
      else begin
        if (pstall) begin
          check("hold_valid", bus.m_valid, 1);
          check("hold_data", bus.m_data, pdata);
          check("hold_last", bus.m_last, plast);
        end
        if (bus.m_valid && first_mv < 0) first_mv = cyc;
        if (bus.m_valid && bus.m_ready) begin
          o.data = $signed(bus.m_data);
          o.last = bus.m_last;
          got_q.push_back(o);
        end
        pstall = bus.m_valid && !bus.m_ready;
        pdata  = bus.m_data;
        plast  = bus.m_last;
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_m_valid"}, bus.m_valid, 0);
    check({name, "_m_data"}, bus.m_data, 0);
    check({name, "_m_last"}, bus.m_last, 0);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_overflow"}, bus.overflow, 0);
  endtask

  task automatic rand_tile();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        tile_v[r][c] = int'($urandom) >>> $urandom_range(0, 31);
  endtask

  initial begin
    int t0, t;
    logic [N*D_W_ACC-1:0] d;
    bus.in_valid = '0;
    bus.in_data  = '0;
    set_cfg(1, 0);
    fork
      rdy_drv();
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Identity tile, skewed rows, latency from first captured row-0 value
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) tile_v[r][c] = 10*r + c;
    first_mv = -1;
    t0 = cyc;
    send_tile(1);
    drain_check("t1", 16);
    check("t1_latency", first_mv - t0, 3);
    for (int i = 0; i < 16 && i < last_got.size(); i++) begin
      check("t1_value", last_got[i].data, 10*(i/N) + i%N);
      check("t1_last", last_got[i].last, i == 15);
    end

    // Saturation and rounding vectors, each broadcast over a whole tile
    vt[0]  = '{300, 1, 0, 127};       vt[1]  = '{-300, 1, 0, -128};
    vt[2]  = '{127, 1, 0, 127};       vt[3]  = '{-128, 1, 0, -128};
    vt[4]  = '{128, 1, 0, 127};       vt[5]  = '{10, 3, 2, 8};
    vt[6]  = '{-10, 3, 2, -7};        vt[7]  = '{1, 3, 2, 1};
    vt[8]  = '{-1, 3, 2, -1};         vt[9]  = '{7, -5, 1, -17};
    vt[10] = '{-77, 256, 8, -77};     vt[11] = '{100, 1000, 4, 127};
    vt[12] = '{2147483647, 32767, 31, 127};
    vt[13] = '{-5, 1, 1, -2};
    for (int i = 0; i < 14; i++) begin
      set_cfg(vt[i].scale, vt[i].shift);
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) tile_v[r][c] = vt[i].acc;
      send_tile(0);
      drain_check("vec", 16);
      if (last_got.size() > 0) check($sformatf("vec%0d", i), last_got[0].data, vt[i].exp);
    end

    // Backpressure for 20 cycles mid-tile while the next tile streams in
    set_cfg(2, 1);
    fork
      begin
        rand_tile(); send_tile(2);
        rand_tile(); send_tile(0);
      end
      begin
        t = 0;
        while (got_q.size() < 5 && t < 500) begin @(negedge clk); t++; end
        check("bp_started", got_q.size() >= 5, 1);
        rdy_mode = 2;
        repeat (20) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain_check("bp", 32);
    check("bp_overflow", bus.overflow, 0);

    // Randomized tiles, config and ready
    for (int k = 0; k < 6; k++) begin
      set_cfg(int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 20));
      rand_tile();
      rdy_mode = 1;
      send_tile($urandom_range(0, 3));
      drain_check("rand", 16);
      rdy_mode = 0;
    end
    repeat (4) @(posedge clk); #1;
    check("rand_idle_busy", bus.busy, 0);

    // Overflow: two entries sit in the stalled pipeline, then 16 fill row 0's FIFO
    set_cfg(1, 0);
    rdy_mode = 2;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 18; i++) begin
      d = '0;
      d[D_W_ACC-1:0] = 1000 + i;
      put(4'b0001, d);
    end
    check("ovf_before", bus.overflow, 0);
    bus.in_data  = '0;
    bus.in_data[D_W_ACC-1:0] = 9999;
    bus.in_valid = 4'b0001;
    @(posedge clk); #1;
    bus.in_valid = '0;
    check("ovf_set", bus.overflow, 1);
    for (int i = 0; i < 16; i++) begin
      d = '0;
      for (int r = 1; r < N; r++) d[r*D_W_ACC +: D_W_ACC] = 2000 + 100*r + i;
      put(4'b1110, d);
    end
    rdy_mode = 0;
    drain_check("ovf", 64);
    check("ovf_sticky", bus.overflow, 1);

    // Clear leftovers, then reset after 5 outputs of a tile
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check("rst_clears_ovf", bus.overflow, 0);
    rand_tile();
    send_tile(0);
    wait_got("pre_rst", 5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    repeat (10) @(posedge clk); #1;
    check("no_partial_after_rst", got_q.size(), 0);
    rand_tile();
    send_tile(2);
    drain_check("post_rst", 16);
    repeat (4) @(posedge clk); #1;
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
